card_dealer: RTL
================

Name: card_dealer

Overview:
- Draws cards without replacement from one 52-card deck on behalf of two requesters: req[0] = player FSM, req[1] = dealer FSM.
- Contains a free-running 32-bit LFSR as the random source.
- Arbitrates requesters round-robin and linear-probes past used cards, so every draw ends in bounded time.
- Sits between the game-control FSMs and the score/display logic.

Parameters:
- SEED, 32'hFFFFFFF1, LFSR reset value; must be nonzero.
- RR_INIT, 1'b0, requester index holding priority after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- shuffle  in  1  pulse; return all 52 cards to the deck.
- req  in  2  draw request per requester; held until own gnt.
- gnt  out  2  one-hot; pulses with card_valid to the served requester.
- card_valid  out  1  one-cycle pulse; card fields valid.
- card_idx  out  6  0..51.
- card_rank  out  4  1..13 (A..K).
- card_suit  out  2  0..3.
- card_value  out  4  blackjack value: A=1, 2..10 face value, J/Q/K=10.
- cards_left  out  6  52..0.
- deck_empty  out  1  cards_left==0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (async on rst):
  - state=IDLE, used mask=0, cards_left=52.
  - gnt=0, card_valid=0, card fields=0.
  - RR pointer=RR_INIT, shuffle_pend=0.
  - LFSR=SEED.
- LFSR:
  - Shifts every cycle outside reset: next = {r[30:0], r[31]^r[21]^r[1]^r[0]}.
  - Never held, including in IDLE.
- FSM states: IDLE, SHUF, PICK, PROBE, DEAL.
- IDLE:
  - shuffle or shuffle_pend set -> SHUF. Shuffle has priority over req.
  - Else any req and !deck_empty -> PICK. Latch the winner: the requester with priority if it requests, otherwise the other.
  - req while deck_empty: ignored, no gnt issued. Requester watches deck_empty.
- SHUF (1 cycle): used=0, cards_left=52, shuffle_pend=0 -> IDLE.
- PICK (1 cycle):
  - cand = r[5:0], minus 52 if r[5:0]>=52. Bias toward 0..11 is accepted.
  - -> PROBE.
- PROBE:
  - used[cand]==0 -> set used[cand], cards_left-1, register card fields -> DEAL.
  - Else cand = (cand==51) ? 0 : cand+1, stay in PROBE. Wrap 51->0.
- DEAL (1 cycle):
  - card_valid=1, gnt[winner]=1.
  - Priority passes to the other requester -> IDLE.
- Latency and throughput:
  - req rises in IDLE at cycle 0 -> card_valid at cycle 3 minimum.
  - Worst case cycle 54 (51 extra probes).
  - One draw per ≥4 cycles.
- Field decode: rank = idx%13 + 1, suit = idx/13, value = min(rank,10).
- shuffle pulse outside IDLE: sets shuffle_pend. The draw in flight completes normally; SHUF runs on the next IDLE.
- Dropping req mid-draw: the draw still completes and the card is consumed; gnt still pulses.
- Both req high in IDLE: priority holder served first. The other is served on the next IDLE pass if still requesting.
- rst mid-draw: immediate abort. Deck is full again and no gnt is issued.

Optional Feature:
- CARD_DEALER_SEED_LOAD_EN defined:
  - Adds ports seed_load (in, 1) and seed (in, 32).
  - seed_load=1 in IDLE loads the LFSR with seed (0 is replaced by SEED) the next cycle; it takes priority over the shift.
  - seed_load is ignored outside IDLE.
- Undefined: ports absent; the LFSR is seeded only by reset.

Decomposition:
- Package card_pkg:
  - Constants: NUM_CARDS=52, NUM_RANKS=13.
  - Typedefs: card_idx_t (logic[5:0]), card_t struct {rank, suit, value}, dealer_state_e enum.
  - Function decode_card(card_idx_t) -> card_t.
- Sub-module dealer_lfsr: 32-bit LFSR with async active-high reset, SEED parameter, optional load port.

Test Plan:
- Reset, no req for 10 cycles -> gnt=0, card_valid=0, cards_left=52, busy=0; LFSR matches reference model shifted 10 times from 32'hFFFFFFF1.
- req=2'b01 held -> card_valid and gnt=2'b01 exactly 3 cycles after IDLE sample; cards_left=51; card_idx matches model's folded r[5:0] at PICK.
- req=2'b11 held for 52 draws -> gnt alternates 01,10,01…; all 52 card_idx distinct; rank/suit/value decode correct (idx 10 -> rank 11, value 10); deck_empty=1 afterwards.
- With 51 cards used, force a PICK candidate above the free slot -> probe wraps 51->0; card_valid within 54 cycles.
- req while deck_empty=1 for 20 cycles -> no gnt; shuffle pulse -> cards_left=52 two cycles later, pending req served.
- shuffle pulse during PROBE -> current card delivered, then SHUF; assert rst mid-PROBE -> outputs at reset values same cycle.

Source files
------------

// File: rtl/card_pkg.sv
// Shared types, constants and card decode for the card dealer.
package card_pkg;

   localparam int unsigned NUM_CARDS = 52;
   localparam int unsigned NUM_RANKS = 13;
   localparam int unsigned IDX_W     = 6;
   localparam int unsigned LFSR_W    = 32;

   typedef logic [IDX_W-1:0] card_idx_t;

   typedef struct packed {
      logic [3:0] rank;
      logic [1:0] suit;
      logic [3:0] value;
   } card_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHUF  = 3'd1,
      ST_PICK  = 3'd2,
      ST_PROBE = 3'd3,
      ST_DEAL  = 3'd4
   } dealer_state_e;

   // rank = idx%13+1 (A..K), suit = idx/13, blackjack value caps faces at 10
   function automatic card_t decode_card(input card_idx_t idx);
      card_t       c;
      int unsigned i;
      int unsigned r;
      i       = 32'(idx);
      r       = (i % NUM_RANKS) + 1;
      c.rank  = 4'(r);
      c.suit  = 2'(i / NUM_RANKS);
      c.value = (r > 10) ? 4'd10 : 4'(r);
      return c;
   endfunction

   // Map a 6-bit random value onto 0..51; the low indices are slightly favoured.
   function automatic card_idx_t fold_cand(input logic [IDX_W-1:0] r);
      return (r >= IDX_W'(NUM_CARDS)) ? r - IDX_W'(NUM_CARDS) : r;
   endfunction

endpackage

// File: rtl/dealer_lfsr.sv
// Free-running 32-bit Fibonacci LFSR (taps 31,21,1,0); exposes the low 6 bits.
// CARD_DEALER_SEED_LOAD_EN adds a synchronous seed load that overrides the shift.
module dealer_lfsr
   import card_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 32'hFFFFFFF1
) (
   input  logic              clk,
   input  logic              rst,
`ifdef CARD_DEALER_SEED_LOAD_EN
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
`endif
   output logic [IDX_W-1:0]  rnd
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;
   logic [LFSR_W-1:0] shift_c;

   assign shift_c = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

   // A zero seed would lock the register up, so it falls back to SEED.
   always_comb begin
`ifdef CARD_DEALER_SEED_LOAD_EN
      lfsr_d = shift_c;
      if (load) begin
         lfsr_d = (load_val == '0) ? SEED : load_val;
      end
`else
      lfsr_d = shift_c;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign rnd = lfsr_q[IDX_W-1:0];

endmodule

// File: rtl/card_dealer.sv
// Draws cards without replacement for two round-robin requesters.
// CARD_DEALER_SEED_LOAD_EN adds seed_load/seed ports for reseeding the LFSR in IDLE.
module card_dealer
   import card_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED    = 32'hFFFFFFF1,
   parameter logic              RR_INIT = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shuffle,
   input  logic [1:0]        req,
`ifdef CARD_DEALER_SEED_LOAD_EN
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
`endif
   output logic [1:0]        gnt,
   output logic              card_valid,
   output logic [IDX_W-1:0]  card_idx,
   output logic [3:0]        card_rank,
   output logic [1:0]        card_suit,
   output logic [3:0]        card_value,
   output logic [IDX_W-1:0]  cards_left,
   output logic              deck_empty,
   output logic              busy
);

   dealer_state_e           state_q, state_d;
   logic [NUM_CARDS-1:0]    used_q, used_d;
   logic [IDX_W-1:0]        left_q, left_d;
   logic                    empty_q, empty_d;
   logic                    busy_q, busy_d;
   card_idx_t               cand_q, cand_d;
   logic                    winner_q, winner_d;
   logic                    rr_q, rr_d;
   logic                    pend_q, pend_d;
   logic [1:0]              gnt_q, gnt_d;
   logic                    valid_q, valid_d;
   card_idx_t               idx_q, idx_d;
   card_t                   card_q, card_d;
   logic [IDX_W-1:0]        rnd;

   dealer_lfsr #(.SEED(SEED)) u_lfsr (
      .clk      (clk),
      .rst      (rst),
`ifdef CARD_DEALER_SEED_LOAD_EN
      .load     (seed_load && (state_q == ST_IDLE)),
      .load_val (seed),
`endif
      .rnd      (rnd)
   );

   // Next-state and datapath for the draw sequence.
   always_comb begin
      state_d  = state_q;
      used_d   = used_q;
      left_d   = left_q;
      cand_d   = cand_q;
      winner_d = winner_q;
      rr_d     = rr_q;
      pend_d   = pend_q;
      idx_d    = idx_q;
      card_d   = card_q;
      gnt_d    = '0;
      valid_d  = 1'b0;

      // A shuffle arriving mid-draw waits for the next IDLE.
      if (shuffle && (state_q != ST_IDLE) && (state_q != ST_SHUF)) begin
         pend_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (shuffle || pend_q) begin
               state_d = ST_SHUF;
            end else if ((req != 2'b00) && !empty_q) begin
               winner_d = req[rr_q] ? rr_q : ~rr_q;
               state_d  = ST_PICK;
            end
         end
         ST_SHUF: begin
            used_d  = '0;
            left_d  = IDX_W'(NUM_CARDS);
            pend_d  = 1'b0;
            state_d = ST_IDLE;
         end
         ST_PICK: begin
            cand_d  = fold_cand(rnd);
            state_d = ST_PROBE;
         end
         ST_PROBE: begin
            if (!used_q[cand_q]) begin
               used_d[cand_q]  = 1'b1;
               left_d          = left_q - IDX_W'(1);
               idx_d           = cand_q;
               card_d          = decode_card(cand_q);
               valid_d         = 1'b1;
               gnt_d[winner_q] = 1'b1;
               state_d         = ST_DEAL;
            end else begin
               cand_d = (cand_q == IDX_W'(NUM_CARDS - 1)) ? '0 : cand_q + IDX_W'(1);
            end
         end
         ST_DEAL: begin
            rr_d    = ~winner_q;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      empty_d = (left_d == '0);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         used_q   <= '0;
         left_q   <= IDX_W'(NUM_CARDS);
         empty_q  <= 1'b0;
         busy_q   <= 1'b0;
         cand_q   <= '0;
         winner_q <= 1'b0;
         rr_q     <= RR_INIT;
         pend_q   <= 1'b0;
         gnt_q    <= '0;
         valid_q  <= 1'b0;
         idx_q    <= '0;
         card_q   <= '0;
      end else begin
         state_q  <= state_d;
         used_q   <= used_d;
         left_q   <= left_d;
         empty_q  <= empty_d;
         busy_q   <= busy_d;
         cand_q   <= cand_d;
         winner_q <= winner_d;
         rr_q     <= rr_d;
         pend_q   <= pend_d;
         gnt_q    <= gnt_d;
         valid_q  <= valid_d;
         idx_q    <= idx_d;
         card_q   <= card_d;
      end
   end

   assign gnt        = gnt_q;
   assign card_valid = valid_q;
   assign card_idx   = idx_q;
   assign card_rank  = card_q.rank;
   assign card_suit  = card_q.suit;
   assign card_value = card_q.value;
   assign cards_left = left_q;
   assign deck_empty = empty_q;
   assign busy       = busy_q;

endmodule
